// File: rtl/noc_pkg.sv
// Shared router constants, flit classification and crossbar select encoding
// used by the switch allocator and its round-robin arbiters.
package noc_pkg;

  localparam int N_PORTS = 5;
  localparam int PORT_W  = 3;
  localparam int SEL_W   = 6;
  localparam logic [SEL_W-1:0] SEL_IDLE = 6'h3F;

  // Encoded as {head, tail} so a flit's type falls straight out of its flags.
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  function automatic flit_e flit_type(input logic head, input logic tail);
    return flit_e'({head, tail});
  endfunction

  function automatic logic is_last(input flit_e ft);
    return (ft == FLIT_TAIL) || (ft == FLIT_SINGLE);
  endfunction

  function automatic logic [SEL_W-1:0] sel_code(input logic [PORT_W-1:0] out_idx,
                                                input logic [PORT_W-1:0] in_idx);
    return SEL_W'(out_idx) * SEL_W'(N_PORTS) + SEL_W'(in_idx);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Five-way round-robin arbiter: the search starts one past ptr and wraps,
// returning a one-hot grant and its index.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]  idx
);

  logic [PORT_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = PORT_W'((int'(ptr) + k) % N_PORTS);
      if ((gnt == '0) && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output packet-locking allocator for the 5x5 crossbar with downstream credit gating.
// state     | meaning
// ST_IDLE   | output free; arbitrating among head flits addressed to it
// ST_LOCKED | output owned by owner_q until its tail flit transfers
module switch_allocator
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CRD_W     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        in_valid,
  input  logic [N_PORTS-1:0]        in_head,
  input  logic [N_PORTS-1:0]        in_tail,
  input  logic [N_PORTS*PORT_W-1:0] in_dest,
  input  logic [N_PORTS-1:0]        credit_ret,
  output logic [N_PORTS-1:0]        in_ready,
  output logic [N_PORTS-1:0]        out_valid,
  output logic [N_PORTS*SEL_W-1:0]  xbar_sel,
  output logic [N_PORTS-1:0]        out_busy,
  output logic                      err_dest
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(BUF_DEPTH);

  alloc_state_e      state_q  [N_PORTS];
  alloc_state_e      state_d  [N_PORTS];
  logic [PORT_W-1:0] owner_q  [N_PORTS];
  logic [PORT_W-1:0] owner_d  [N_PORTS];
  logic [PORT_W-1:0] rr_ptr_q [N_PORTS];
  logic [PORT_W-1:0] rr_ptr_d [N_PORTS];
  logic [CRD_W-1:0]  credit_q [N_PORTS];
  logic [CRD_W-1:0]  credit_d [N_PORTS];
  logic              err_dest_q;
  logic              err_dest_d;

  logic [N_PORTS-1:0] owns;
  logic [N_PORTS-1:0] head_req;
  logic [N_PORTS-1:0] bad_dest;
  logic [N_PORTS-1:0] xfer;
  logic [N_PORTS-1:0] arb_req [N_PORTS];
  logic [N_PORTS-1:0] arb_gnt [N_PORTS];
  logic [PORT_W-1:0]  arb_idx [N_PORTS];

  // An input already holding an output is masked so it can never own two at once.
  always_comb begin
    owns     = '0;
    head_req = '0;
    bad_dest = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      arb_req[o] = '0;
      if (state_q[o] == ST_LOCKED) owns[owner_q[o]] = 1'b1;
    end
    for (int i = 0; i < N_PORTS; i++) begin
      head_req[i] = in_valid[i] & in_head[i];
      bad_dest[i] = head_req[i] && (in_dest[i*PORT_W +: PORT_W] > PORT_W'(N_PORTS-1));
      for (int o = 0; o < N_PORTS; o++) begin
        arb_req[o][i] = head_req[i] & ~owns[i] & (in_dest[i*PORT_W +: PORT_W] == PORT_W'(o));
      end
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req (arb_req[o]),
      .ptr (rr_ptr_q[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o])
    );
  end

  always_comb begin
    in_ready   = '0;
    out_valid  = '0;
    out_busy   = '0;
    xfer       = '0;
    xbar_sel   = {N_PORTS{SEL_IDLE}};
    err_dest_d = err_dest_q | (|bad_dest);
    for (int o = 0; o < N_PORTS; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      credit_d[o] = credit_q[o];
      if (state_q[o] == ST_LOCKED) begin
        out_busy[o]                   = 1'b1;
        xbar_sel[o*SEL_W +: SEL_W]    = sel_code(PORT_W'(o), owner_q[o]);
        xfer[o]                       = in_valid[owner_q[o]] && (credit_q[o] != '0);
        out_valid[o]                  = xfer[o];
        if (xfer[o]) begin
          in_ready[owner_q[o]] = 1'b1;
          if (is_last(flit_type(in_head[owner_q[o]], in_tail[owner_q[o]]))) begin
            state_d[o]  = ST_IDLE;
            rr_ptr_d[o] = owner_q[o];
          end
        end
      end else if (|arb_gnt[o]) begin
        state_d[o] = ST_LOCKED;
        owner_d[o] = arb_idx[o];
      end
      // A return at full depth is dropped; a return alongside a send cancels out.
      if (xfer[o] && !credit_ret[o]) begin
        credit_d[o] = credit_q[o] - 1'b1;
      end else if (!xfer[o] && credit_ret[o] && (credit_q[o] != CRD_MAX)) begin
        credit_d[o] = credit_q[o] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_PORTS; o++) begin
        state_q[o]  <= ST_IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= PORT_W'(N_PORTS-1);
        credit_q[o] <= CRD_MAX;
      end
      err_dest_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      credit_q   <= credit_d;
      err_dest_q <= err_dest_d;
    end
  end

  assign err_dest = err_dest_q;

endmodule
